cmd_vec_loader: RTL and testbench
=================================

// Module: cmd_vec_loader
// PURPOSE
//  Front-end stage between the UART receiver and the coprocessor datapath.
//  Parses the received byte stream into commands, fills vector memories A and B, and presents op.
//  Holds op stable until the downstream transmitter pulses op_finished, then re-arms for the next command.
// PARAMETERS
//  N        1024        elements per vector (bytes); index width = $clog2(N)
//  GAP_MAX  10_000_000  max idle clk cycles between payload bytes (used only with RX_GAP_TIMEOUT_EN)
// PORTS
//  clk          in   1       system clock; all state changes on posedge
//  rst_n        in   1       asynchronous reset, active-low
//  rx_data      in   8       byte from UART receiver
//  rx_ready     in   1       1-cycle strobe: rx_data valid
//  op_finished  in   1       1-cycle strobe from transmitter: current op fully sent
//  out_a        out  8 x N   vector A memory contents
//  out_b        out  8 x N   vector B memory contents
//  op           out  8       active operation code; 0 = idle
//  busy         out  1       1 while in LOAD_A, LOAD_B or EXEC
//  load_done    out  1       1-cycle pulse after the N-th payload byte is written
//  load_err     out  1       1-cycle pulse on payload abort (timeout); 0 when timeout is compiled out
// BEHAVIOUR
//  Reset values: op=0, busy=0, load_done=0, load_err=0, idx=0, state=IDLE.
//    out_a/out_b are NOT reset; their contents are retained across reset.
//  States: IDLE, LOAD_A, LOAD_B, EXEC.
//  IDLE: act only when rx_ready=1. Decode rx_data:
//    CMD_WR_A (8'd1)  -> LOAD_A, idx=0
//    CMD_WR_B (8'd2)  -> LOAD_B, idx=0
//    OP_READ_A 99, OP_READ_B 100, OP_SUM 101, OP_AVG 102, OP_MAN 103
//                     -> op<=rx_data; go to EXEC
//    any other value  -> ignored; stay in IDLE; no output change
//  LOAD_x: each rx_ready writes out_x[idx]<=rx_data on the same edge, then idx++.
//    The write is visible on out_x the cycle after the strobe.
//    On the write with idx==N-1: load_done pulses the next cycle, idx->0, state->IDLE, op remains 0.
//    Payload bytes are data only, never decoded as commands.
//  EXEC: op is held constant and busy=1. rx_ready is ignored (byte dropped).
//    On op_finished: op<=0, ->IDLE; the first command is accepted the cycle after.
//  Simultaneous rx_ready and op_finished in EXEC: op_finished is serviced; the byte is dropped.
//  op_finished outside EXEC: ignored.
//  Latency: the command byte strobe at edge k gives op valid and busy=1 after edge k.
//  Async reset mid-LOAD: bytes already written stay in memory; idx=0; state=IDLE.
//    The next payload must be preceded by a new command.
//  Async reset mid-EXEC: op=0 immediately (asynchronous).
// CONFIGURATION
//  RX_GAP_TIMEOUT_EN defined:
//    a gap counter runs in LOAD_A/LOAD_B, cleared on each rx_ready.
//    When it reaches GAP_MAX: load_err pulses 1 cycle, idx=0, ->IDLE.
//    Partial data remains in memory.
//  RX_GAP_TIMEOUT_EN undefined:
//    no counter; LOAD waits indefinitely; load_err is tied to 0; GAP_MAX is unused.
// STRUCTURE
//  coproc_pkg: opcode constants (OP_IDLE=0, OP_READ_A..OP_MAN), CMD_WR_A/CMD_WR_B,
//    state enum loader_state_t, and function is_exec_op(byte) -> bit.
//  Sub-module gap_timer (counter + terminal pulse, clear/enable inputs).
//    Instantiated only under RX_GAP_TIMEOUT_EN.
//  Memories out_a/out_b are plain register arrays written by this block.
// TESTING
//  1. Reset, send 8'd1 then bytes 0..N-1 (value = idx%256)
//     -> out_a[i]==i%256; load_done pulses once; busy=0 after; op stays 0.
//  2. Load B with 8'd2 + N bytes of 8'h05, then send 101
//     -> op==101 the cycle after the strobe; busy=1.
//     Pulse op_finished -> op==0 next cycle.
//  3. In EXEC (op=103), send 8'd1 with rx_ready together with op_finished
//     -> op->0, state IDLE, out_a unchanged; byte not treated as a command.
//  4. In IDLE send 8'd7, then 8'd200
//     -> no state change, op==0, busy==0.
//  5. Send 8'd1 + 10 bytes, assert rst_n=0 for 1 cycle, then send 8'd1 + N bytes
//     -> out_a[0..9] are overwritten correctly; exactly 1 load_done.
//  6. (RX_GAP_TIMEOUT_EN, GAP_MAX=50) Send 8'd2 + 3 bytes, then idle 60 cycles
//     -> load_err pulses at gap 50; state IDLE.
//     A following 101 -> op==101.

Source files
------------

// File: rtl/coproc_pkg.sv
// rtl/coproc_pkg.sv - opcode/command constants, loader state enum and opcode classifier
package coproc_pkg;

  localparam logic [7:0] OP_IDLE   = 8'd0;
  localparam logic [7:0] CMD_WR_A  = 8'd1;
  localparam logic [7:0] CMD_WR_B  = 8'd2;
  localparam logic [7:0] OP_READ_A = 8'd99;
  localparam logic [7:0] OP_READ_B = 8'd100;
  localparam logic [7:0] OP_SUM    = 8'd101;
  localparam logic [7:0] OP_AVG    = 8'd102;
  localparam logic [7:0] OP_MAN    = 8'd103;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_A = 2'd1,
    LOAD_B = 2'd2,
    EXEC   = 2'd3
  } loader_state_t;

  function automatic bit is_exec_op(input logic [7:0] b);
    return (b == OP_READ_A) || (b == OP_READ_B) || (b == OP_SUM) ||
           (b == OP_AVG) || (b == OP_MAN);
  endfunction

endpackage

// File: rtl/gap_timer.sv
// rtl/gap_timer.sv - idle-gap counter; expired is high in the cycle whose edge completes MAX idle cycles
module gap_timer #(
  parameter int MAX = 10_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic clear,
  output logic expired
);

  localparam int CW = $clog2(MAX + 1);

  logic [CW-1:0] cnt;

  assign expired = enable && !clear && (cnt == CW'(MAX - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear || !enable || expired) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/cmd_vec_loader.sv
// rtl/cmd_vec_loader.sv - UART byte-stream command parser, vector A/B loader and op holder
// Optional payload gap timeout enabled by defining RX_GAP_TIMEOUT_EN.
module cmd_vec_loader
  import coproc_pkg::*;
#(
  parameter int N       = 1024,
  parameter int GAP_MAX = 10_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_ready,
  input  logic       op_finished,
  output logic [7:0] out_a [N],
  output logic [7:0] out_b [N],
  output logic [7:0] op,
  output logic       busy,
  output logic       load_done,
  output logic       load_err
);

  localparam int IW = $clog2(N);
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  loader_state_t state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [7:0]    op_d;
  logic          load_done_d, load_err_d;
  logic          wr_a, wr_b;
  logic          in_load;
  logic          gap_expired;

  assign in_load = (state_q == LOAD_A) || (state_q == LOAD_B);
  assign busy    = in_load || (state_q == EXEC);

`ifdef RX_GAP_TIMEOUT_EN
  gap_timer #(.MAX(GAP_MAX)) u_gap_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .enable  (in_load),
    .clear   (rx_ready),
    .expired (gap_expired)
  );
`else
  assign gap_expired = (GAP_MAX < 0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      op        <= OP_IDLE;
      load_done <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      op        <= op_d;
      load_done <= load_done_d;
      load_err  <= load_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (rx_ready) begin
          if (rx_data == CMD_WR_A) begin
            state_d = LOAD_A;
            idx_d   = '0;
          end else if (rx_data == CMD_WR_B) begin
            state_d = LOAD_B;
            idx_d   = '0;
          end else if (is_exec_op(rx_data)) begin
            state_d = EXEC;
          end
        end
      end
      LOAD_A, LOAD_B: begin
        if (rx_ready) begin
          if (idx_q == LAST) begin
            idx_d   = '0;
            state_d = IDLE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else if (gap_expired) begin
          idx_d   = '0;
          state_d = IDLE;
        end
      end
      EXEC: begin
        // Any byte arriving here is dropped, even alongside op_finished.
        if (op_finished) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_a        = (state_q == LOAD_A) && rx_ready;
    wr_b        = (state_q == LOAD_B) && rx_ready;
    load_done_d = (wr_a || wr_b) && (idx_q == LAST);
    load_err_d  = in_load && gap_expired;
    op_d        = op;
    if ((state_q == IDLE) && rx_ready && is_exec_op(rx_data)) begin
      op_d = rx_data;
    end else if ((state_q == EXEC) && op_finished) begin
      op_d = OP_IDLE;
    end
  end

  // Vector memories carry no reset so partial payloads survive a reset.
  always_ff @(posedge clk) begin
    if (wr_a) out_a[idx_q] <= rx_data;
    if (wr_b) out_b[idx_q] <= rx_data;
  end

endmodule

// File: tb/tb_cmd_vec_loader.sv
// tb/tb_cmd_vec_loader.sv - scoreboard bench for cmd_vec_loader (small N, GAP_MAX=50)
module tb_cmd_vec_loader;
  import coproc_pkg::*;

  localparam int N       = 16;
  localparam int GAP_MAX = 50;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = 8'd0;
  logic       rx_ready = 1'b0;
  logic       op_finished = 1'b0;
  logic [7:0] out_a [N];
  logic [7:0] out_b [N];
  logic [7:0] op;
  logic       busy, load_done, load_err;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int err_cnt = 0;

  typedef struct {
    bit         vec_b;
    int         idx;
    logic [7:0] val;
  } mem_exp_t;

  mem_exp_t   mem_q [$];
  logic [7:0] op_q [$];
  logic [7:0] model_a [N];
  logic [7:0] model_b [N];

  cmd_vec_loader #(.N(N), .GAP_MAX(GAP_MAX)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_data     (rx_data),
    .rx_ready    (rx_ready),
    .op_finished (op_finished),
    .out_a       (out_a),
    .out_b       (out_b),
    .op          (op),
    .busy        (busy),
    .load_done   (load_done),
    .load_err    (load_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (load_done) done_cnt++;
    if (load_err) err_cnt++;
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic pulse_finished();
    @(negedge clk);
    op_finished = 1'b1;
    @(negedge clk);
    op_finished = 1'b0;
  endtask

  task automatic load(input logic [7:0] cmd, input int count, input int base, input int step);
    logic [7:0] v;
    send_byte(cmd);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL load_busy cmd=%0d got=%b exp=1", cmd, busy);
    end
    for (int i = 0; i < count; i++) begin
      v = 8'(base + step * i);
      send_byte(v);
      if (cmd == CMD_WR_B) model_b[i] = v;
      else model_a[i] = v;
      mem_q.push_back('{vec_b: (cmd == CMD_WR_B), idx: i, val: v});
    end
  endtask

  task automatic drain_mem(input string tag);
    mem_exp_t   e;
    logic [7:0] got;
    while (mem_q.size() > 0) begin
      e   = mem_q.pop_front();
      got = e.vec_b ? out_b[e.idx] : out_a[e.idx];
      checks++;
      if (got !== e.val) begin
        errors++;
        $display("FAIL %s mem_%s[%0d] got=%h exp=%h", tag, e.vec_b ? "b" : "a", e.idx, got, e.val);
      end
    end
  endtask

  task automatic send_op(input logic [7:0] code, input string tag);
    logic [7:0] exp;
    op_q.push_back(code);
    send_byte(code);
    exp = op_q.pop_front();
    checks++;
    if (op !== exp) begin
      errors++;
      $display("FAIL %s op got=%0d exp=%0d", tag, op, exp);
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL %s busy got=%b exp=1", tag, busy);
    end
  endtask

  task automatic test_reset();
    #12;
    checks++; if (op !== 8'd0) begin errors++; $display("FAIL reset_op got=%0d exp=0", op); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL reset_load_done got=%b exp=0", load_done); end
    checks++; if (load_err !== 1'b0) begin errors++; $display("FAIL reset_load_err got=%b exp=0", load_err); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_load_a();
    int d0;
    d0 = done_cnt;
    load(CMD_WR_A, N, 0, 1);
    checks++; if (load_done !== 1'b1) begin errors++; $display("FAIL load_a_done_pulse got=%b exp=1", load_done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL load_a_busy_after got=%b exp=0", busy); end
    checks++; if (op !== 8'd0) begin errors++; $display("FAIL load_a_op got=%0d exp=0", op); end
    @(negedge clk);
    checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL load_a_done_width got=%b exp=0", load_done); end
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL load_a_done_count got=%0d exp=1", done_cnt - d0); end
    drain_mem("load_a");
  endtask

  task automatic test_exec_sum();
    load(CMD_WR_B, N, 5, 0);
    drain_mem("load_b");
    send_op(OP_SUM, "exec_sum");
    send_byte(CMD_WR_A);
    checks++; if (op !== OP_SUM) begin errors++; $display("FAIL exec_hold_op got=%0d exp=%0d", op, OP_SUM); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL exec_hold_busy got=%b exp=1", busy); end
    pulse_finished();
    checks++; if (op !== 8'd0) begin errors++; $display("FAIL exec_finish_op got=%0d exp=0", op); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL exec_finish_busy got=%b exp=0", busy); end
    send_op(OP_READ_A, "exec_rearm");
    pulse_finished();
  endtask

  task automatic test_simultaneous();
    send_op(OP_MAN, "simul_man");
    @(negedge clk);
    rx_data     = CMD_WR_A;
    rx_ready    = 1'b1;
    op_finished = 1'b1;
    @(negedge clk);
    rx_ready    = 1'b0;
    op_finished = 1'b0;
    checks++; if (op !== 8'd0) begin errors++; $display("FAIL simul_op got=%0d exp=0", op); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL simul_busy got=%b exp=0", busy); end
    send_byte(8'h77);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL simul_not_cmd_busy got=%b exp=0", busy); end
    checks++; if (out_a[0] !== model_a[0]) begin errors++; $display("FAIL simul_out_a0 got=%h exp=%h", out_a[0], model_a[0]); end
  endtask

  task automatic test_ignored();
    send_byte(8'd7);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ignore7_busy got=%b exp=0", busy); end
    checks++; if (op !== 8'd0) begin errors++; $display("FAIL ignore7_op got=%0d exp=0", op); end
    send_byte(8'd200);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ignore200_busy got=%b exp=0", busy); end
    checks++; if (op !== 8'd0) begin errors++; $display("FAIL ignore200_op got=%0d exp=0", op); end
  endtask

  task automatic test_reset_mid_load();
    int d0;
    d0 = done_cnt;
    load(CMD_WR_A, 10, 8'hC0, 1);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midload_busy got=%b exp=1", busy); end
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midload_reset_busy got=%b exp=0", busy); end
    drain_mem("midload_retained");
    load(CMD_WR_A, N, 8'hF0, -1);
    @(negedge clk);
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL midload_done_count got=%0d exp=1", done_cnt - d0); end
    drain_mem("midload_reload");
  endtask

  task automatic test_reset_mid_exec();
    send_op(OP_AVG, "rst_exec_avg");
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (op !== 8'd0) begin errors++; $display("FAIL rst_exec_op got=%0d exp=0", op); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_exec_busy got=%b exp=0", busy); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

`ifdef RX_GAP_TIMEOUT_EN
  task automatic test_gap_timeout();
    int n;
    load(CMD_WR_B, 3, 8'h30, 1);
    n = 0;
    while (load_err !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++; if (n !== GAP_MAX) begin errors++; $display("FAIL gap_err_cycle got=%0d exp=%0d", n, GAP_MAX); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL gap_busy got=%b exp=0", busy); end
    drain_mem("gap_partial");
    send_op(OP_SUM, "gap_then_sum");
    pulse_finished();
  endtask
`endif

  initial begin
    test_reset();
    test_load_a();
    test_exec_sum();
    test_simultaneous();
    test_ignored();
    test_reset_mid_load();
    test_reset_mid_exec();
`ifdef RX_GAP_TIMEOUT_EN
    test_gap_timeout();
    checks++; if (err_cnt !== 1) begin errors++; $display("FAIL load_err_count got=%0d exp=1", err_cnt); end
`else
    checks++; if (err_cnt !== 0) begin errors++; $display("FAIL load_err_count got=%0d exp=0", err_cnt); end
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
